// File: rtl/mem_access.sv
//------------------------------------------------------------------------------
// Module   : mem_access
// Purpose  : Memory-access pipeline stage. ALU results pass straight through
//            with one cycle of latency; loads and stores stall the upstream
//            stage, issue a single word-aligned request with byte enables,
//            wait for mack (bounded by TIMEOUT cycles) and return the
//            sign/zero-extended load value or an error.
// Ports    : CLK, RST (async active-low)
//            Ins/Result/Rdata2/in_valid  - execute-stage inputs
//            stall                       - upstream hold
//            out_valid/WBdata/err        - write-back result
//            mreq/mwe/maddr/mbe/mwdata   - memory request
//            mrdata/mack                 - memory response
// Config   : MEM_ALIGN_CHECK_EN - when defined, misaligned halfword/word
//            accesses are rejected with err=1 and never reach memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  input  logic        in_valid,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] WBdata,
  output logic        err,
  output logic        mreq,
  output logic        mwe,
  output logic [31:0] maddr,
  output logic [3:0]  mbe,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack
);

  localparam logic [5:0] c_op_lb  = 6'h20;
  localparam logic [5:0] c_op_lh  = 6'h21;
  localparam logic [5:0] c_op_lw  = 6'h23;
  localparam logic [5:0] c_op_lbu = 6'h24;
  localparam logic [5:0] c_op_lhu = 6'h25;
  localparam logic [5:0] c_op_sb  = 6'h28;
  localparam logic [5:0] c_op_sh  = 6'h29;
  localparam logic [5:0] c_op_sw  = 6'h2B;

  localparam logic [1:0] c_sz_byte = 2'd0;
  localparam logic [1:0] c_sz_half = 2'd1;
  localparam logic [1:0] c_sz_word = 2'd2;

  localparam int             c_cw       = $clog2(TIMEOUT + 1);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state, w_next;

  // Operation captured at acceptance
  logic [1:0]      r_size;
  logic            r_signed;
  logic            r_store;
  logic [1:0]      r_lo;
  logic [c_cw-1:0] r_cnt;

  // Registered outputs
  logic            r_out_valid;
  logic [31:0]     r_wbdata;
  logic            r_err;
  logic [31:0]     r_maddr;
  logic [3:0]      r_mbe;
  logic [31:0]     r_mwdata;
  logic            r_mwe;

  // Decode of the incoming instruction
  logic [5:0]  w_opc;
  logic        w_is_mem;
  logic        w_is_store;
  logic        w_signed;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic        w_timeout;

  // Load extraction
  logic [7:0]  w_lane8;
  logic [15:0] w_lane16;
  logic [31:0] w_load;

  // Only the opcode field of Ins matters here
  logic w_unused;
  assign w_unused = ^Ins[25:0];

  assign w_opc = Ins[31:26];

  always_comb begin
    w_is_mem   = 1'b1;
    w_is_store = 1'b0;
    w_signed   = 1'b0;
    w_size     = c_sz_word;
    case (w_opc)
      c_op_lb:  begin w_size = c_sz_byte; w_signed = 1'b1; end
      c_op_lh:  begin w_size = c_sz_half; w_signed = 1'b1; end
      c_op_lw:  w_size = c_sz_word;
      c_op_lbu: w_size = c_sz_byte;
      c_op_lhu: w_size = c_sz_half;
      c_op_sb:  begin w_size = c_sz_byte; w_is_store = 1'b1; end
      c_op_sh:  begin w_size = c_sz_half; w_is_store = 1'b1; end
      c_op_sw:  begin w_size = c_sz_word; w_is_store = 1'b1; end
      default:  w_is_mem = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data; memory picks the lanes
  always_comb begin
    case (w_size)
      c_sz_byte: begin
        w_be    = 4'b0001 << Result[1:0];
        w_wdata = {4{Rdata2[7:0]}};
      end
      c_sz_half: begin
        w_be    = Result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{Rdata2[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = Rdata2;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = ((w_size == c_sz_half) && Result[0]) ||
                      ((w_size == c_sz_word) && (Result[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    case (r_lo)
      2'd1:    w_lane8 = mrdata[15:8];
      2'd2:    w_lane8 = mrdata[23:16];
      2'd3:    w_lane8 = mrdata[31:24];
      default: w_lane8 = mrdata[7:0];
    endcase
    w_lane16 = r_lo[1] ? mrdata[31:16] : mrdata[15:0];
    case (r_size)
      c_sz_byte: w_load = {{24{r_signed & w_lane8[7]}}, w_lane8};
      c_sz_half: w_load = {{16{r_signed & w_lane16[15]}}, w_lane16};
      default:   w_load = mrdata;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state and state-derived outputs
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    stall     = 1'b0;
    mreq      = 1'b0;
    mwe       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && w_is_mem) begin
          stall  = 1'b1;
          w_next = w_misalign ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        mreq  = 1'b1;
        mwe   = r_mwe;
        // mack on the final counted cycle still wins over the timeout
        if (mack) begin
          w_next = DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      DONE: begin
        stall  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // in_valid can be high during reset; keep stall low regardless
    if (!RST) stall = 1'b0;
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_size      <= c_sz_byte;
      r_signed    <= 1'b0;
      r_store     <= 1'b0;
      r_lo        <= 2'd0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_wbdata    <= 32'd0;
      r_err       <= 1'b0;
      r_maddr     <= 32'd0;
      r_mbe       <= 4'd0;
      r_mwdata    <= 32'd0;
      r_mwe       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (!w_is_mem) begin
              r_out_valid <= 1'b1;
              r_wbdata    <= Result;
              r_err       <= 1'b0;
            end else begin
              r_size   <= w_size;
              r_signed <= w_signed;
              r_store  <= w_is_store;
              r_lo     <= Result[1:0];
              r_cnt    <= '0;
              r_maddr  <= {Result[31:2], 2'b00};
              r_mbe    <= w_be;
              r_mwdata <= w_wdata;
              r_mwe    <= w_is_store;
              if (w_misalign) begin
                r_out_valid <= 1'b1;
                r_wbdata    <= 32'd0;
                r_err       <= 1'b1;
              end
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + c_cw'(1);
          if (mack) begin
            r_out_valid <= 1'b1;
            r_wbdata    <= r_store ? 32'd0 : w_load;
            r_err       <= 1'b0;
          end else if (w_timeout) begin
            r_out_valid <= 1'b1;
            r_wbdata    <= 32'd0;
            r_err       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign WBdata    = r_wbdata;
  assign err       = r_err;
  assign maddr     = r_maddr;
  assign mbe       = r_mbe;
  assign mwdata    = r_mwdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access. Directed cases followed by
//            randomized transactions compared against a transaction-level
//            model of the access rules.
// Config   : honours MEM_ALIGN_CHECK_EN the same way as the design.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access;

  localparam int TIMEOUT = 16;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_ADD = 6'h00;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Ins;
  logic [31:0] Result;
  logic [31:0] Rdata2;
  logic        in_valid;
  logic        stall;
  logic        out_valid;
  logic [31:0] WBdata;
  logic        err;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [3:0]  mbe;
  logic [31:0] mwdata;
  logic [31:0] mrdata;
  logic        mack;

  int checks   = 0;
  int failures = 0;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Ins      (Ins),
    .Result   (Result),
    .Rdata2   (Rdata2),
    .in_valid (in_valid),
    .stall    (stall),
    .out_valid(out_valid),
    .WBdata   (WBdata),
    .err      (err),
    .mreq     (mreq),
    .mwe      (mwe),
    .maddr    (maddr),
    .mbe      (mbe),
    .mwdata   (mwdata),
    .mrdata   (mrdata),
    .mack     (mack)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_mem(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic bit m_is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // access size in bytes
  function automatic int m_bytes(input logic [5:0] op);
    if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
    return 4;
  endfunction

  function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (a % m_bytes(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
    int b;
    b = m_bytes(op);
    if (b == 1) return 4'(1 << (a % 4));
    if (b == 2) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v;
    case (op)
      OP_LB, OP_LBU: begin
        v = (r >> (8 * (a % 4))) & 32'hFF;
        if (op == OP_LB && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      OP_LH, OP_LHU: begin
        v = (r >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
        if (op == OP_LH && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  // byte that must appear on lane n of the store data bus
  function automatic logic [7:0] m_lane(input logic [5:0] op, input logic [31:0] w, input int n);
    int b;
    b = m_bytes(op);
    if (b == 1) return w[7:0];
    if (b == 2) return 8'(w >> (8 * (n % 2)));
    return 8'(w >> (8 * n));
  endfunction

  // ---------------- one transaction ----------------
  // d: REQ-cycle index at which mack is returned (>= TIMEOUT means never)
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] r, input int d);
    bit          mem, seen;
    int          nreq, exp_nreq;
    logic [31:0] exp_wb;
    logic        exp_err;
    logic [3:0]  be;
    mem  = m_is_mem(op);
    seen = 1'b0;
    nreq = 0;
    @(negedge CLK);
    Ins      = {op, 26'($urandom)};
    Result   = a;
    Rdata2   = w;
    in_valid = 1'b1;
    mack     = 1'($urandom_range(0, 1));   // idle-time mack must be ignored
    mrdata   = $urandom;
    #1;
    check("stall_at_accept", 32'(stall), 32'(mem));
    if (!mem) begin
      @(negedge CLK); #1;
      check("alu_out_valid", 32'(out_valid), 32'd1);
      check("alu_wbdata", WBdata, a);
      check("alu_err", 32'(err), 32'd0);
      check("alu_stall", 32'(stall), 32'd0);
      in_valid = 1'b0;
      mack     = 1'b0;
      return;
    end
    if (m_misaligned(op, a)) begin
      exp_nreq = 0; exp_err = 1'b1; exp_wb = 32'd0;
    end else if (d < TIMEOUT) begin
      exp_nreq = d + 1; exp_err = 1'b0;
      exp_wb   = m_is_store(op) ? 32'd0 : m_load(op, a, r);
    end else begin
      exp_nreq = TIMEOUT; exp_err = 1'b1; exp_wb = 32'd0;
    end
    be = m_be(op, a);
    for (int cyc = 0; cyc < TIMEOUT + 8 && !seen; cyc++) begin
      @(negedge CLK); #1;
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        check("stall_busy", 32'(stall), 32'd1);
        if (mreq) begin
          if (nreq == 0) begin
            check("maddr", maddr, a & 32'hFFFF_FFFC);
            check("mbe", 32'(mbe), 32'(be));
            check("mwe", 32'(mwe), 32'(m_is_store(op)));
            if (m_is_store(op))
              for (int n = 0; n < 4; n++)
                if (be[n]) check("mwdata_lane", 32'(mwdata[8*n +: 8]), 32'(m_lane(op, w, n)));
          end
          mack   = (nreq == d);
          mrdata = (nreq == d) ? r : $urandom;
          nreq++;
        end else begin
          mack = 1'b0;
        end
      end
    end
    check("out_valid_seen", 32'(seen), 32'd1);
    check("mreq_cycles", 32'(nreq), 32'(exp_nreq));
    check("mem_wbdata", WBdata, exp_wb);
    check("mem_err", 32'(err), 32'(exp_err));
    check("done_stall", 32'(stall), 32'd1);
    check("done_mreq", 32'(mreq), 32'd0);
    in_valid = 1'b0;
    mack     = 1'b0;
    @(negedge CLK); #1;
    check("ov_single_pulse", 32'(out_valid), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
  endtask

  logic [5:0] ops_mem [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  initial begin
    logic [5:0]  op;
    logic [31:0] v;
    RST = 1'b0; Ins = '0; Result = '0; Rdata2 = '0; in_valid = 1'b0;
    mrdata = '0; mack = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mreq", 32'(mreq), 32'd0);
    check("rst_wbdata", WBdata, 32'd0);
    check("rst_maddr", maddr, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // directed cases
    run_op(OP_ADD, 32'h1234, 32'h0, 32'h0, 0);
    run_op(OP_LB, 32'h101, 32'h0, 32'h0000_8000, 2);
    run_op(OP_SH, 32'h202, 32'hABCD, 32'h0, 1);
    run_op(OP_LW, 32'h40, 32'h0, 32'h0, 1000);          // never acked
    run_op(OP_LW, 32'h3, 32'h0, 32'hCAFE_F00D, 0);
    run_op(OP_LHU, 32'h11, 32'h0, 32'h8001_7FFE, TIMEOUT - 1);  // ack on last cycle

    // back-to-back ALU ops, one result per cycle
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      v        = $urandom;
      Ins      = {OP_ADD, 26'($urandom)};
      Result   = v;
      in_valid = 1'b1;
      #1;
      check("b2b_stall", 32'(stall), 32'd0);
      @(negedge CLK); #1;
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      check("b2b_wbdata", WBdata, v);
    end
    in_valid = 1'b0;

    // reset in the middle of a request
    @(negedge CLK);
    Ins = {OP_LW, 26'd0}; Result = 32'h0000_0080; Rdata2 = 32'h5A5A_5A5A;
    in_valid = 1'b1; mack = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    check("pre_rst_mreq", 32'(mreq), 32'd1);
    RST = 1'b0;
    #1;
    check("midrst_ctrl", {26'd0, stall, out_valid, err, mreq, mwe, 1'b0}, 32'd0);
    check("midrst_mbe", 32'(mbe), 32'd0);
    check("midrst_maddr", maddr, 32'd0);
    check("midrst_mwdata", mwdata, 32'd0);
    check("midrst_wbdata", WBdata, 32'd0);
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      check("post_rst_no_ov", 32'(out_valid), 32'd0);
    end
    run_op(OP_LW, 32'h84, 32'h0, 32'h1357_9BDF, 3);

    // randomized transactions
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (m_is_mem(op));
      end else begin
        op = ops_mem[$urandom_range(0, 7)];
      end
      run_op(op, $urandom, $urandom, $urandom,
             ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                         : $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
